// File: rtl/inst_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_responder_pkg
//   Shared constants and types for the instruction-memory responder.
//   - XLEN          : address/data width of the fetch interface
//   - NOP_INSTR     : word returned on a faulting fetch (addi x0, x0, 0)
//   - e_imem_state  : responder FSM encoding (IDLE/READ/WAIT/RESP)
//   - fetch_fault() : misaligned / out-of-range classification of a fetch
// ---------------------------------------------------------------------------
package inst_mem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // FSM state encoding kept as plain 2-bit constants so older blocks that
    // compare against raw values keep working.
    typedef logic [1:0] e_imem_state;
    localparam e_imem_state IMEM_IDLE = 2'd0;
    localparam e_imem_state IMEM_READ = 2'd1;
    localparam e_imem_state IMEM_WAIT = 2'd2;
    localparam e_imem_state IMEM_RESP = 2'd3;

    // A fetch faults when the byte address is not word aligned or when its
    // word index falls outside the memory.
    function automatic logic fetch_fault(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[XLEN-1:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// ---------------------------------------------------------------------------
// inst_mem_responder_if
//   Fetch-stage <-> instruction-memory bus.
//   Request side : inst_request, inst_addr, flush (driven by fetch)
//                  req_ready (driven by responder)
//   Response side: inst_valid, inst_data, inst_resp_addr, inst_fault
//                  (driven by responder)
//
//   Handshake: a request transfers on the rising clk edge where
//   inst_request && req_ready are both high; the fetch stage keeps
//   inst_request and inst_addr stable until that edge. req_ready never
//   depends on inst_request. Responses have no back-pressure: inst_valid is
//   a single-cycle pulse and the payload lines hold their last value while
//   inst_valid is low. A request presented together with flush is always
//   taken as the redirect target.
// ---------------------------------------------------------------------------
interface inst_mem_responder_if;
    import inst_mem_responder_pkg::*;

    logic            inst_request;
    logic [XLEN-1:0] inst_addr;
    logic            flush;
    logic            req_ready;
    logic            inst_valid;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_resp_addr;
    logic            inst_fault;

    modport master (
        output inst_request, inst_addr, flush,
        input  req_ready, inst_valid, inst_data, inst_resp_addr, inst_fault
    );

    modport slave (
        input  inst_request, inst_addr, flush,
        output req_ready, inst_valid, inst_data, inst_resp_addr, inst_fault
    );

endinterface

// File: rtl/inst_mem_responder_inst_req_fifo.sv
// ---------------------------------------------------------------------------
// inst_req_fifo
//   Synchronous FIFO holding outstanding fetch addresses.
//   clk, rstn : clock, asynchronous active-low reset (pointers only)
//   push/din  : write din when not full (or when clear is also asserted)
//   pop/dout  : dout shows the head; pop removes it when not empty
//   clear     : empties the queue; a simultaneous push becomes the only entry
//   full, empty, count : occupancy status
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module inst_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

    logic [IW:0]      wptr;
    logic [IW:0]      rptr;
    logic [WIDTH-1:0] store [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [IW-1:0]    widx;

    assign do_push = push & (clear | ~full);
    assign do_pop  = pop & ~empty & ~clear;
    // On clear the queue restarts at slot 0, so a redirect push lands there.
    assign widx    = clear ? '0 : wptr[IW-1:0];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[widx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            rptr <= '0;
            wptr <= do_push ? PTR_ONE : '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    assign dout  = store[rptr[IW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//   Instruction-memory responder for the fetch stage. Queues fetch requests,
//   reads a word-addressed instruction RAM with optional wait states and
//   returns one response per request, in order.
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : fetch bus (slave side), see inst_mem_responder_if
//   load_we    : loader write enable (writes are never dropped)
//   load_addr  : loader word index
//   load_data  : loader write data
//   dbg_state  : current FSM state (IMEM_IDLE/READ/WAIT/RESP)
// ---------------------------------------------------------------------------
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    inst_mem_responder_if.slave          bus,
    input  logic                         load_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output e_imem_state                  dbg_state
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] DEPTH_WORDS = XLEN'(MEM_DEPTH);
    localparam logic [3:0]      WAIT_INIT   = 4'(WAIT_STATES);
    localparam logic [CW-1:0]   ONE_ENTRY   = CW'(1);

    // ---------------- request queue ----------------
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] head_addr;

    // A request riding along with flush is the redirect target and must be
    // taken even when the queue is full, since the queue is being emptied.
    assign fifo_push = bus.inst_request & (~fifo_full | bus.flush);

    inst_req_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (bus.flush),
        .din   (bus.inst_addr),
        .dout  (head_addr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.req_ready = ~fifo_full;

    // ---------------- instruction memory ----------------
    logic [31:0] mem [MEM_DEPTH];
    logic        head_fault;
    logic [31:0] rd_word;

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign head_fault = fetch_fault(head_addr, DEPTH_WORDS);

    // Faulting fetches never touch the array; they return a NOP instead.
    always_comb begin
        rd_word = NOP_INSTR;
        if (!head_fault) begin
            rd_word = mem[head_addr[AW+1:2]];
        end
    end

    // ---------------- control FSM ----------------
    e_imem_state     state;
    logic [3:0]      wait_cnt;
    logic [31:0]     hold_data;
    logic [XLEN-1:0] hold_addr;
    logic            hold_fault;
    logic [31:0]     out_data;
    logic [XLEN-1:0] out_addr;
    logic            out_fault;
    logic            resp_more;

    // After this cycle's pop, is there still an entry to serve?
    assign resp_more = (fifo_count > ONE_ENTRY) | fifo_push;
    assign fifo_pop  = (state == IMEM_RESP) & ~bus.flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IMEM_IDLE;
            wait_cnt   <= '0;
            hold_data  <= '0;
            hold_addr  <= '0;
            hold_fault <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_fault  <= 1'b0;
        end else if (bus.flush) begin
            state    <= IMEM_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IMEM_IDLE: begin
                    if (!fifo_empty) begin
                        state <= IMEM_READ;
                    end
                end
                IMEM_READ: begin
                    // The RAM is single ported: a loader write wins the port
                    // and the read is retried on the following cycle.
                    if (!load_we) begin
                        hold_data  <= rd_word;
                        hold_addr  <= head_addr;
                        hold_fault <= head_fault;
                        wait_cnt   <= WAIT_INIT;
                        if (WAIT_STATES == 0) begin
                            out_data  <= rd_word;
                            out_addr  <= head_addr;
                            out_fault <= head_fault;
                            state     <= IMEM_RESP;
                        end else begin
                            state <= IMEM_WAIT;
                        end
                    end
                end
                IMEM_WAIT: begin
                    // Payload is published only on entry to RESP so the
                    // response lines hold steady while inst_valid is low.
                    if (wait_cnt <= 4'd1) begin
                        out_data  <= hold_data;
                        out_addr  <= hold_addr;
                        out_fault <= hold_fault;
                        wait_cnt  <= '0;
                        state     <= IMEM_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                IMEM_RESP: begin
                    state <= resp_more ? IMEM_READ : IMEM_IDLE;
                end
                default: begin
                    state <= IMEM_IDLE;
                end
            endcase
        end
    end

    assign bus.inst_valid     = (state == IMEM_RESP) & ~bus.flush;
    assign bus.inst_data      = out_data;
    assign bus.inst_resp_addr = out_addr;
    assign bus.inst_fault     = out_fault;
    assign dbg_state          = state;

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;
    import inst_mem_responder_pkg::*;

    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // Two instances: sel 0 -> WAIT_STATES=0, sel 1 -> WAIT_STATES=3
    inst_mem_responder_if bus_a ();
    inst_mem_responder_if bus_b ();
    logic        load_we_a, load_we_b;
    logic [9:0]  load_addr_a, load_addr_b;
    logic [31:0] load_data_a, load_data_b;
    e_imem_state dbg_a, dbg_b;

    inst_mem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a), .load_we(load_we_a),
        .load_addr(load_addr_a), .load_data(load_data_a), .dbg_state(dbg_a));

    inst_mem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b), .load_we(load_we_b),
        .load_addr(load_addr_b), .load_data(load_data_b), .dbg_state(dbg_b));

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl_mem [2][DEPTH];
    logic [31:0] lx_data [2];
    logic [31:0] lx_addr [2];
    logic        lx_fault[2];

    // Reference: the word at a byte address, or a NOP fault for bad addresses.
    function automatic logic [32:0] mdl_resp(input int sel, input logic [31:0] a);
        if ((a % 4) != 0 || (a / 4) >= DEPTH) return {1'b1, 32'h0000_0013};
        return {1'b0, mdl_mem[sel][a / 4]};
    endfunction

    function automatic int ws_of(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    function automatic logic g_valid(input int sel);
        return (sel == 0) ? bus_a.inst_valid : bus_b.inst_valid;
    endfunction
    function automatic logic g_ready(input int sel);
        return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction
    function automatic logic [31:0] g_data(input int sel);
        return (sel == 0) ? bus_a.inst_data : bus_b.inst_data;
    endfunction
    function automatic logic [31:0] g_addr(input int sel);
        return (sel == 0) ? bus_a.inst_resp_addr : bus_b.inst_resp_addr;
    endfunction
    function automatic logic g_fault(input int sel);
        return (sel == 0) ? bus_a.inst_fault : bus_b.inst_fault;
    endfunction
    function automatic e_imem_state g_dbg(input int sel);
        return (sel == 0) ? dbg_a : dbg_b;
    endfunction

    function automatic logic [31:0] rand_addr();
        int c;
        c = $urandom_range(0, 9);
        if (c == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (c == 1) return 32'($urandom_range(DEPTH, 8 * DEPTH)) << 2;
        if (c == 2) return ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic req, input logic [31:0] addr, input logic fl);
        if (sel == 0) begin
            bus_a.inst_request = req; bus_a.inst_addr = addr; bus_a.flush = fl;
        end else begin
            bus_b.inst_request = req; bus_b.inst_addr = addr; bus_b.flush = fl;
        end
    endtask

    task automatic load_word(input int sel, input int idx, input logic [31:0] data);
        if (sel == 0) begin
            load_we_a = 1'b1; load_addr_a = 10'(idx); load_data_a = data;
        end else begin
            load_we_b = 1'b1; load_addr_b = 10'(idx); load_data_b = data;
        end
        tick();
        load_we_a = 1'b0;
        load_we_b = 1'b0;
        mdl_mem[sel][idx] = data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            n_tests++; if (g_valid(s) !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", s, g_valid(s)); end
            n_tests++; if (g_ready(s) !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", s, g_ready(s)); end
            n_tests++; if (g_data(s) !== 32'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", s, g_data(s)); end
            n_tests++; if (g_addr(s) !== 32'h0) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h want 0", s, g_addr(s)); end
            n_tests++; if (g_fault(s) !== 1'b0) begin n_fail++; $display("FAIL reset_fault[%0d]: got %b want 0", s, g_fault(s)); end
            n_tests++; if (g_dbg(s) !== IMEM_IDLE) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d want IDLE", s, g_dbg(s)); end
            lx_data[s] = '0; lx_addr[s] = '0; lx_fault[s] = 1'b0;
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic load_init();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                load_word(s, i, (i < 4) ? 32'h1111_1111 * (i + 1) : $urandom);
            end
        end
    endtask

    task automatic test_latency();
        drive(0, 1'b1, 32'h0, 1'b0);
        tick();                          // accepted at edge N
        drive(0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (g_valid(0) !== 1'b0) begin n_fail++; $display("FAIL lat_n0: valid got %b want 0", g_valid(0)); end
        tick();
        n_tests++; if (g_valid(0) !== 1'b0) begin n_fail++; $display("FAIL lat_n1: valid got %b want 0", g_valid(0)); end
        tick();
        n_tests++; if (g_valid(0) !== 1'b1) begin n_fail++; $display("FAIL lat_n2: valid got %b want 1", g_valid(0)); end
        n_tests++; if (g_data(0) !== 32'h1111_1111) begin n_fail++; $display("FAIL lat_data: got %h want 11111111", g_data(0)); end
        n_tests++; if (g_addr(0) !== 32'h0) begin n_fail++; $display("FAIL lat_addr: got %h want 0", g_addr(0)); end
        n_tests++; if (g_fault(0) !== 1'b0) begin n_fail++; $display("FAIL lat_fault: got %b want 0", g_fault(0)); end
        lx_data[0] = 32'h1111_1111; lx_addr[0] = 32'h0; lx_fault[0] = 1'b0;
        tick();
        n_tests++; if (g_valid(0) !== 1'b0) begin n_fail++; $display("FAIL lat_pulse: valid got %b want 0", g_valid(0)); end
        n_tests++; if (g_data(0) !== 32'h1111_1111) begin n_fail++; $display("FAIL lat_hold: data got %h want 11111111", g_data(0)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[3];
        int          acc_k[3];
        int          vk[$];
        int          stall;
        int          idx;
        logic [31:0] a;
        logic [32:0] r;
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        acc_k[0] = -1; acc_k[1] = -1; acc_k[2] = -1;
        stall = 0; idx = 0;
        exp_q.delete();
        for (int k = 0; k < 30; k++) begin
            if (g_valid(0)) begin
                vk.push_back(k);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got response addr %h want none", g_addr(0));
                end else begin
                    a = exp_q.pop_front();
                    r = mdl_resp(0, a);
                    if (g_data(0) !== r[31:0] || g_addr(0) !== a || g_fault(0) !== r[32]) begin
                        n_fail++;
                        $display("FAIL b2b_resp: got %h/%h/%b want %h/%h/%b", g_data(0), g_addr(0), g_fault(0), r[31:0], a, r[32]);
                    end
                    lx_data[0] = r[31:0]; lx_addr[0] = a; lx_fault[0] = r[32];
                end
            end
            if (idx == 3 && exp_q.size() == 0) break;
            if (idx < 3) drive(0, 1'b1, addrs[idx], 1'b0);
            else         drive(0, 1'b0, 32'h0, 1'b0);
            #1;
            if (idx < 3) begin
                if (g_ready(0)) begin
                    acc_k[idx] = k; exp_q.push_back(addrs[idx]); idx++;
                end else begin
                    stall++;
                end
            end
            tick();
        end
        drive(0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (idx != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_done: got %0d accepted %0d pending want 3/0", idx, exp_q.size()); end
        n_tests++; if (stall != 2) begin n_fail++; $display("FAIL b2b_stall: got %0d stalled cycles want 2", stall); end
        n_tests++; if (acc_k[1] - acc_k[0] != 1) begin n_fail++; $display("FAIL b2b_accept2: got gap %0d want 1", acc_k[1] - acc_k[0]); end
        n_tests++;
        if (vk.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d responses want 3", vk.size());
        end else begin
            if (vk[0] != acc_k[0] + 3 || vk[1] - vk[0] != 2 || vk[2] - vk[1] != 2 || acc_k[2] != vk[0] + 1) begin
                n_fail++;
                $display("FAIL b2b_timing: got valid %0d,%0d,%0d acc8 %0d want %0d,+2,+2 acc8 %0d",
                         vk[0], vk[1], vk[2], acc_k[2], acc_k[0] + 3, acc_k[0] + 4);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] addrs[2];
        int          k;
        addrs[0] = 32'h6; addrs[1] = 32'h1000;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b1, addrs[i], 1'b0);
            tick();
            drive(0, 1'b0, 32'h0, 1'b0);
            for (k = 0; k < 8 && !g_valid(0); k++) tick();
            n_tests++;
            if (!g_valid(0)) begin
                n_fail++; $display("FAIL fault_timeout: addr %h got no response want one", addrs[i]);
            end else if (g_fault(0) !== 1'b1 || g_data(0) !== 32'h0000_0013 || g_addr(0) !== addrs[i]) begin
                n_fail++;
                $display("FAIL fault_resp: got %b/%h/%h want 1/00000013/%h", g_fault(0), g_data(0), g_addr(0), addrs[i]);
            end
            lx_data[0] = 32'h0000_0013; lx_addr[0] = addrs[i]; lx_fault[0] = 1'b1;
            tick();
        end
    endtask

    task automatic test_flush();
        int k;
        drive(0, 1'b1, 32'h0, 1'b0);
        tick();
        drive(0, 1'b1, 32'h4, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        tick();                          // RESP for 0x0
        n_tests++; if (g_valid(0) !== 1'b1 || g_addr(0) !== 32'h0) begin n_fail++; $display("FAIL flush_pre: got valid %b addr %h want 1/0", g_valid(0), g_addr(0)); end
        lx_data[0] = mdl_mem[0][0]; lx_addr[0] = 32'h0; lx_fault[0] = 1'b0;
        drive(0, 1'b1, 32'h8, 1'b1);
        #1;
        n_tests++; if (g_valid(0) !== 1'b0) begin n_fail++; $display("FAIL flush_kill: valid got %b want 0", g_valid(0)); end
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        for (k = 0; k < 10; k++) begin
            if (g_valid(0)) break;
            tick();
        end
        n_tests++;
        if (k != 2 || g_addr(0) !== 32'h8 || g_data(0) !== mdl_mem[0][2] || g_fault(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_target: got k=%0d %h/%h want k=2 %h/00000008", k, g_data(0), g_addr(0), mdl_mem[0][2]);
        end
        lx_data[0] = mdl_mem[0][2]; lx_addr[0] = 32'h8; lx_fault[0] = 1'b0;
        tick();
        for (int j = 0; j < 6; j++) begin
            n_tests++; if (g_valid(0) !== 1'b0) begin n_fail++; $display("FAIL flush_stale: got valid addr %h want none", g_addr(0)); end
            tick();
        end
    endtask

    task automatic test_load_during_read();
        drive(0, 1'b1, 32'h4, 1'b0);
        tick();                          // accepted at edge N
        drive(0, 1'b0, 32'h0, 1'b0);
        tick();                          // cycle N+1: READ
        load_we_a = 1'b1; load_addr_a = 10'd1; load_data_a = 32'hDEAD_BEEF;
        mdl_mem[0][1] = 32'hDEAD_BEEF;
        tick();
        load_we_a = 1'b0;
        n_tests++; if (g_valid(0) !== 1'b0) begin n_fail++; $display("FAIL ldrd_delay: valid got %b want 0", g_valid(0)); end
        n_tests++; if (g_dbg(0) !== IMEM_READ) begin n_fail++; $display("FAIL ldrd_state: got %0d want READ", g_dbg(0)); end
        tick();
        n_tests++;
        if (g_valid(0) !== 1'b1 || g_data(0) !== 32'hDEAD_BEEF || g_addr(0) !== 32'h4) begin
            n_fail++; $display("FAIL ldrd_resp: got %b/%h/%h want 1/deadbeef/00000004", g_valid(0), g_data(0), g_addr(0));
        end
        lx_data[0] = 32'hDEAD_BEEF; lx_addr[0] = 32'h4; lx_fault[0] = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        drive(1, 1'b1, 32'hC, 1'b0);
        tick();                          // accepted at edge N
        drive(1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            n_tests++; if (g_valid(1) !== (k == 5)) begin n_fail++; $display("FAIL ws_valid_n%0d: got %b want %b", k, g_valid(1), k == 5); end
            if (k == 5) begin
                n_tests++;
                if (g_data(1) !== 32'h4444_4444 || g_addr(1) !== 32'hC || g_fault(1) !== 1'b0) begin
                    n_fail++; $display("FAIL ws_resp: got %h/%h/%b want 44444444/0000000c/0", g_data(1), g_addr(1), g_fault(1));
                end
            end
            tick();
        end
        lx_data[1] = 32'h4444_4444; lx_addr[1] = 32'hC; lx_fault[1] = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        drive(1, 1'b1, 32'h0, 1'b0);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        n_tests++; if (g_dbg(1) !== IMEM_WAIT) begin n_fail++; $display("FAIL rst_pre: state got %0d want WAIT", g_dbg(1)); end
        rstn = 1'b0;
        #1;
        n_tests++;
        if (g_valid(1) !== 1'b0 || g_ready(1) !== 1'b1 || g_data(1) !== 32'h0 || g_addr(1) !== 32'h0 ||
            g_fault(1) !== 1'b0 || g_dbg(1) !== IMEM_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid: got v%b r%b %h/%h/%b s%0d want v0 r1 0/0/0 s0",
                     g_valid(1), g_ready(1), g_data(1), g_addr(1), g_fault(1), g_dbg(1));
        end
        tick();
        rstn = 1'b1;
        for (int s = 0; s < 2; s++) begin
            lx_data[s] = '0; lx_addr[s] = '0; lx_fault[s] = 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            n_tests++; if (g_valid(1) !== 1'b0) begin n_fail++; $display("FAIL rst_ghost: got valid addr %h want none", g_addr(1)); end
            tick();
        end
    endtask

    task automatic test_random(input int sel, input int n);
        int          issued;
        int          cycles;
        int          last_v;
        logic        pending;
        logic [31:0] cur;
        logic [31:0] a;
        logic [32:0] r;
        issued = 0; cycles = 0; last_v = -100; pending = 1'b0; cur = '0;
        exp_q.delete();
        while ((issued < n || pending || exp_q.size() != 0) && cycles < 2000) begin
            if (g_valid(sel)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd%0d_extra: got response addr %h want none", sel, g_addr(sel));
                end else begin
                    a = exp_q.pop_front();
                    r = mdl_resp(sel, a);
                    if (g_data(sel) !== r[31:0] || g_addr(sel) !== a || g_fault(sel) !== r[32]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_resp: got %h/%h/%b want %h/%h/%b", sel,
                                 g_data(sel), g_addr(sel), g_fault(sel), r[31:0], a, r[32]);
                    end
                    lx_data[sel] = r[31:0]; lx_addr[sel] = a; lx_fault[sel] = r[32];
                end
                n_tests++;
                if (cycles - last_v < 2 + ws_of(sel)) begin
                    n_fail++; $display("FAIL rnd%0d_rate: got gap %0d want >= %0d", sel, cycles - last_v, 2 + ws_of(sel));
                end
                last_v = cycles;
            end else begin
                n_tests++;
                if (g_data(sel) !== lx_data[sel] || g_addr(sel) !== lx_addr[sel] || g_fault(sel) !== lx_fault[sel]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_hold: got %h/%h/%b want %h/%h/%b", sel,
                             g_data(sel), g_addr(sel), g_fault(sel), lx_data[sel], lx_addr[sel], lx_fault[sel]);
                end
            end
            if (!pending && issued < n && $urandom_range(0, 2) != 0) begin
                pending = 1'b1;
                cur = rand_addr();
            end
            drive(sel, pending, cur, 1'b0);
            #1;
            if (pending && g_ready(sel)) begin
                exp_q.push_back(cur);
                pending = 1'b0;
                issued++;
            end
            tick();
            cycles++;
        end
        drive(sel, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (cycles >= 2000) begin
            n_fail++; $display("FAIL rnd%0d_timeout: got %0d outstanding want 0", sel, exp_q.size());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        load_we_a = 1'b0; load_addr_a = '0; load_data_a = '0;
        load_we_b = 1'b0; load_addr_b = '0; load_data_b = '0;

        test_reset();
        load_init();
        test_latency();
        test_back_to_back();
        test_fault();
        test_flush();
        test_load_during_read();
        test_wait_states();
        test_reset_mid_wait();
        test_random(0, 40);
        test_random(1, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule
